// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
package mult_share_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_pick.sv
// Combinational round-robin chooser: first asserted request at or after rr_ptr.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any_req
);

    always_comb begin
        int idx;
        idx     = 0;
        win_idx = '0;
        any_req = |req;
        // Scan from farthest to nearest so the candidate closest to rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                win_idx = IDX_W'(idx);
            end
        end
        gnt_oh = any_req ? (NUM_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Arbitrates NUM_REQ requesters onto one registered multiplier and returns
// each product with a one-cycle done pulse; a silent multiplier is aborted.
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [prod_w(DATA_W)-1:0]   rsp_out,
    output logic [NUM_REQ-1:0]          err,
    output logic                        busy,
    output logic                        mult_en,
    output logic [DATA_W-1:0]           mult_a,
    output logic [DATA_W-1:0]           mult_b,
    input  logic [prod_w(DATA_W)-1:0]   mult_out,
    input  logic                        mult_ack
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_q;
    logic [7:0]         timer;
    logic               aborted;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt_oh  (pick_oh),
        .win_idx (pick_idx),
        .any_req (any_req)
    );

    // NOTE: every register here uses <= so all state updates see pre-edge values;
    // the async reset clears the whole transaction, so an aborted one never emits done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            rsp_out <= '0;
            busy    <= 1'b0;
            mult_en <= 1'b0;
            mult_a  <= '0;
            mult_b  <= '0;
            rr_ptr  <= '0;
            win_q   <= '0;
            timer   <= '0;
            aborted <= 1'b0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= pick_oh;
                        win_q   <= pick_idx;
                        mult_a  <= req_a[int'(pick_idx)*DATA_W +: DATA_W];
                        mult_b  <= req_b[int'(pick_idx)*DATA_W +: DATA_W];
                        mult_en <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    mult_en <= 1'b0;
                    timer   <= '0;
                    aborted <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (mult_ack) begin
                        rsp_out <= mult_out;
                        state   <= RESP;
                    end else if (timer == 8'(TIMEOUT - 1)) begin
                        rsp_out <= '0;
                        aborted <= 1'b1;
                        state   <= RESP;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                RESP: begin
                    done   <= gnt;
                    err    <= aborted ? gnt : '0;
                    gnt    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Shares one registered 8x8 multiplier (en/a/b in; out/ack out, result registered one cycle after en is sampled) between N requesters.
- Round-robin arbitration; captures the winner's operands, sequences the multiplier enable, waits for ack, and returns the 16-bit product with a one-cycle done pulse.
- Sits between testbench/host-side requesters and the multiplier's RTL-side interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, operand width
- TIMEOUT, 15, max cycles in WAIT before abort (1..255)

Ports:
- clk  input  1  clock; all logic on posedge
- reset_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester request level; held until that requester's done
- req_a  input  NUM_REQ*DATA_W  packed operand A, slice i belongs to requester i
- req_b  input  NUM_REQ*DATA_W  packed operand B
- gnt  output  NUM_REQ  one-hot; high from capture until done/abort
- done  output  NUM_REQ  one-hot, one-cycle pulse; result valid
- rsp_out  output  2*DATA_W  product; holds until next done
- err  output  NUM_REQ  one-cycle pulse with done on timeout abort
- busy  output  1  high whenever state != IDLE
- mult_en  output  1  to multiplier en
- mult_a, mult_b  output  DATA_W  to multiplier operands
- mult_out  input  2*DATA_W  from multiplier out
- mult_ack  input  1  from multiplier ack

Behaviour:
- Reset (async, reset_n=0): state=IDLE, gnt=0, done=0, err=0, rsp_out=0, mult_en=0, mult_a=0, mult_b=0, busy=0, rr_ptr=0, timer=0. Takes effect immediately, mid-transaction included; no done is ever issued for an aborted transaction.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req, pick the winner at or after rr_ptr (wrapping NUM_REQ-1 -> 0).
  - Register gnt[w]=1, mult_a/mult_b = winner's operands, mult_en=1; go to ISSUE.
- ISSUE (one cycle): multiplier samples en=1 at this edge. Set mult_en=0, timer=0; go to WAIT.
- WAIT:
  - mult_ack=1: rsp_out <= mult_out; go to RESP.
  - Otherwise increment timer. When timer reaches TIMEOUT-1: rsp_out <= 0, err[w] pulse; go to RESP.
- RESP (one cycle):
  - done[w]=1, gnt cleared, rr_ptr = w+1 mod NUM_REQ; go to IDLE.
  - The requester drops req on seeing done. A req still high in IDLE the next cycle is a new request.
- Latency: IDLE-with-req edge to done high = 4 edges. Min gap between grants is 4 cycles.
- Operands are captured at grant; later changes to req_a/req_b are ignored.
- req dropped before done: the transaction still completes and done still pulses.
- Simultaneous requests: lowest index at or after rr_ptr wins. Others wait; no request is ever starved beyond NUM_REQ-1 transactions.
- mult_ack already high in ISSUE (stale) is ignored; only ack seen in WAIT counts.
- Arithmetic: unsigned; full 2*DATA_W product from the multiplier; no truncation.

Decomposition:
- Package mult_share_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - default DATA_W and NUM_REQ constants
  - product width function
- Sub-module rr_pick:
  - combinational round-robin chooser
  - inputs: req vector, rr_ptr
  - outputs: one-hot grant, winner index, any_req

Test Plan:
- Single request: req[0], a=5, b=6, real multiplier attached -> gnt[0] next edge; done[0] pulse 4 edges after req seen; rsp_out=30; err=0.
- Contention: req[0] (20,7) and req[2] (10,4) asserted same cycle, rr_ptr=0 -> done[0] with rsp_out=140, then done[2] with rsp_out=40; grants never overlap.
- Fairness: all 4 reqs held continuously -> grant order 0,1,2,3,0, one grant per 4 cycles.
- Width corner: a=255, b=255 -> rsp_out=65025; a=0, b=200 -> rsp_out=0.
- Timeout: mult_ack tied 0 -> err[1] and done[1] pulse together after ISSUE + TIMEOUT cycles; rsp_out=0; next request serviced normally.
- Reset mid-WAIT: drop reset_n during WAIT -> all outputs 0 immediately, no done. After release, a fresh req[3] (3,3) gives rsp_out=9.
